// File: rtl/wb_ram_slave.sv
// Wishbone classic slave RAM: 64-bit words, address window decode, programmable
// wait states, single-cycle ack, read data held on dat_o until the next read.
module wb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [63:0] OOR_DATA    = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [63:0] dat_i,
  output logic [63:0] dat_o,
  output logic        ack_o,
  output logic        busy_o,
  output logic [1:0]  state_o
);

  localparam int          IDXW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(8 * DEPTH);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [63:0] dat_q;
  logic [63:0] rdat_q;
  logic        ack_q;
  logic [63:0] mem [DEPTH];

  logic            req;
  logic            enter_ack;
  logic [31:0]     acc_addr;
  logic            acc_we;
  logic [63:0]     acc_dat;
  logic [31:0]     acc_off;
  logic            acc_hit;
  logic [IDXW-1:0] acc_idx;

  assign req = cyc_i & stb_i;

  // Handshake: a request is cyc_i & stb_i seen in IDLE; ack_o answers it with a
  // one-cycle pulse, and HOLD swallows any strobe left high past that pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req) state_d = (WS != 4'd0) ? WAIT : ACK;
      WAIT: begin
        if (!cyc_i)              state_d = IDLE;
        else if (cnt_q == 4'd1)  state_d = ACK;
      end
      ACK:  state_d = HOLD;
      HOLD: if (!stb_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the same edge that leaves IDLE,
  // so the operands come straight from the bus instead of the latches.
  always_comb begin
    acc_addr = addr_q;
    acc_we   = we_q;
    acc_dat  = dat_q;
    if (state_q == IDLE) begin
      acc_addr = addr_i;
      acc_we   = we_i;
      acc_dat  = dat_i;
    end
  end

  assign enter_ack = (state_d == ACK) && (state_q != ACK);
  assign acc_off   = acc_addr - BASE_ADDR;
  assign acc_hit   = acc_off < SPAN;
  assign acc_idx   = acc_off[IDXW+2:3];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      we_q    <= 1'b0;
      dat_q   <= 64'h0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= enter_ack;
      if (state_q == IDLE && req) begin
        cnt_q  <= WS;
        addr_q <= addr_i;
        we_q   <= we_i;
        dat_q  <= dat_i;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdat_q <= 64'h0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 64'h0;
    end else if (enter_ack) begin
      if (acc_we) begin
        if (acc_hit) mem[acc_idx] <= acc_dat;
      end else begin
        rdat_q <= acc_hit ? mem[acc_idx] : OOR_DATA;
      end
    end
  end

  assign dat_o   = rdat_q;
  assign ack_o   = ack_q;
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule
